fetch_unit: RTL

//   Instruction fetch stage sitting upstream of the cpu datapath. Drives the synchronous

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. The head entry is read straight from
// the storage registers. A flush empties the FIFO and takes priority over a
// push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                wr_en_s;

  // Next-state for pointers and count; a flush resets everything.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en_s = push_i;
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the synchronous instruction ROM, buffers
// fetched {pc, instr} pairs in fetch_fifo and presents them downstream over
// valid/ready. A redirect flushes the buffer, drops any response still in
// flight and restarts fetch at the new address.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic [AW:0]  count_s;
  logic [AW+1:0] occ_s;
  logic         pop_s, push_s, issue_s;
  logic [31:0]  issue_addr_s;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;
  logic         unused_s;

  assign unused_s    = ^redirect_pc[1:0];
  assign occ_s       = {1'b0, count_s} + (AW+2)'(inflight_q);
  assign out_valid   = (count_s != '0);
  assign pop_s       = out_valid & out_ready;
  // A response arriving in a redirect cycle belongs to the old stream: kill it.
  assign push_s      = inflight_q & ~redirect_valid;
  assign push_data_s = '{pc: inflight_pc_q, instr: imem_rdata};

  // Issue decision: redirect wins; otherwise fetch while the buffer has room.
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = fetch_pc_q;
    if (redirect_valid) begin
      issue_s      = 1'b1;
      issue_addr_s = {redirect_pc[31:2], 2'b00};
    end else if ((occ_s < (AW+2)'(DEPTH)) ||
                 ((occ_s == (AW+2)'(DEPTH)) && pop_s)) begin
      issue_s      = 1'b1;
      issue_addr_s = fetch_pc_q;
    end else begin
      issue_s      = 1'b0;
      issue_addr_s = fetch_pc_q;
    end
  end

  // Next fetch address and in-flight tracking.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue_s;
    inflight_pc_d = inflight_pc_q;
    if (issue_s) begin
      fetch_pc_d    = issue_addr_s + INSTR_BYTES;
      inflight_pc_d = issue_addr_s;
    end else begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
    end
  end

  // Fetch pointer and in-flight request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // ROM strobe is held off while reset is asserted.
  assign imem_req  = reset & issue_s;
  assign imem_addr = issue_addr_s;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid),
    .count_o     (count_s),
    .head_o      (head_s)
  );

  assign out_pc    = head_s.pc;
  assign out_instr = head_s.instr;

  // Sequential successor of the presented pc; zero when nothing is presented.
  always_comb begin
    out_pc_plus_4 = 32'h0000_0000;
    if (out_valid) begin
      out_pc_plus_4 = head_s.pc + INSTR_BYTES;
    end else begin
      out_pc_plus_4 = 32'h0000_0000;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;

  // Handshake and discard counters; discards are the entries left after a
  // same-cycle pop plus any killed in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= 32'h0000_0000;
      perf_flushed_q <= 32'h0000_0000;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(pop_s);
      if (redirect_valid) begin
        perf_flushed_q <= perf_flushed_q + 32'(count_s) + 32'(inflight_q) - 32'(pop_s);
      end else begin
        perf_flushed_q <= perf_flushed_q;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule : fetch_unit
